trace_uart_tx: RTL and testbench
================================

Name: trace_uart_tx

Overview:
Debug trace port downstream of the processor core. Captures (pc_out, instruction) pairs on a strobe, buffers them in a small FIFO, and formats each pair as an ASCII hex line. Each line is serialized on a UART 8N1 pin for an off-board terminal. It is the on-hardware counterpart of the LCD instruction display.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal values are 2 and above.
FIFO_DEPTH, 8, number of trace entries; must be a power of 2.
ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
valid  input  1  capture strobe; samples pc_in and instr_in on the same edge
pc_in  input  16  processor pc_out
instr_in  input  16  processor instruction
tx  output  1  UART serial out, idle high
busy  output  1  FIFO non-empty, or formatter/UART not idle
overflow  output  1  sticky: at least one capture was dropped
fifo_count  output  ADDR_W+1  number of entries in the FIFO

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, overflow=0, fifo_count=0, FIFO pointers=0, formatter in IDLE, UART in IDLE. Reset mid-frame aborts the frame immediately and leaves no residual output after release.
- FIFO push:
  - A push is accepted when valid=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle).
  - valid=1 on a full FIFO with no same-cycle pop drops the entry and sets overflow=1.
  - overflow clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Formatter FSM states: IDLE, LOAD, SEND, WAIT.
  - IDLE: if FIFO is non-empty, pop into a 32-bit line register {pc, instr}, clear char index to 0, go to LOAD.
  - LOAD: select character[idx], go to SEND.
  - SEND: pulse start to the UART for one cycle, go to WAIT.
  - WAIT: on UART done, if idx==10 go to IDLE; otherwise increment idx and go to LOAD.
- Line format, 11 bytes:
  - idx 0-3: pc nibbles [15:12] down to [3:0].
  - idx 4: 0x20 (space).
  - idx 5-8: instr nibbles, MSB nibble first.
  - idx 9: 0x0D. idx 10: 0x0A.
- Hex encoding is uppercase: nibble n<10 maps to 0x30+n; otherwise 0x41+(n-10).
- UART 8N1:
  - On start, latch the byte and drive tx=0 for CLKS_PER_BIT cycles (start bit).
  - Then send 8 data bits LSB first, each CLKS_PER_BIT cycles.
  - Then tx=1 for CLKS_PER_BIT cycles (stop bit).
  - Assert done for one cycle at the end of the stop bit. A frame is exactly 10*CLKS_PER_BIT cycles.
  - A start pulse while the UART is busy is ignored; the FSM guarantees this never happens.
- Timing:
  - Capture into an empty idle block at edge E: pop at E+1, LOAD at E+2, start at E+3, tx falls at E+4.
  - Inter-character gap within a line is 3 cycles (WAIT to LOAD to SEND to start).
- busy is registered from the next-state values so that it is high at least until tx returns idle after the final LF.

Decomposition:
- Shared package trace_pkg:
  - ASCII constants: SPACE=0x20, CR=0x0D, LF=0x0A, ZERO=0x30, UPPER_A=0x41.
  - Formatter state encoding (2 bits).
  - LINE_LEN=11.
  - Function hex_ascii(nibble) returning 8 bits.
- One sub-module, uart_tx_8n1 (params: CLKS_PER_BIT; ports: clk, reset, start, data[7:0], tx, done, active).
- The FIFO and formatter stay inline in trace_uart_tx.

Test Plan:
All tests use CLKS_PER_BIT=4, so one frame is 40 cycles.
1. Reset hold then release, no valid -> tx=1, busy=0, overflow=0, fifo_count=0 for 200 cycles.
2. One capture pc=0x0004, instr=0xA1F3 -> UART decodes bytes 30 30 30 34 20 41 31 46 33 0D 0A. tx falls 4 cycles after the capture edge. busy drops after the last stop bit. Total line time 11*40+10*3 cycles.
3. Bit-level check on byte 0x41 -> start bit low for exactly 4 cycles; data bits 1,0,0,0,0,0,1,0 (LSB first), 4 cycles each; stop bit high for 4 cycles.
4. Ten consecutive valid cycles with distinct pc 0x0000..0x0009 -> entries 0..8 are accepted (pop at cycle 1 frees a slot). fifo_count peaks at 8. The 10th capture is dropped and overflow=1. Exactly 9 lines appear, in order; no line for pc 0x0009.
5. pc=0xFFFF, instr=0x0000 -> "FFFF 0000\r\n" (46 46 46 46 20 30 30 30 30 0D 0A).
6. Three lines queued, reset pulsed low during data bit 3 of the second line -> tx=1 in the same cycle (asynchronous). fifo_count=0, busy=0, overflow=0. No further tx activity after release until a new valid arrives.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace UART: ASCII constants,
// formatter state encoding, the FIFO entry layout and the nibble-to-hex helper.
package trace_pkg;

  localparam logic [7:0] SPACE   = 8'h20;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] ZERO    = 8'h30;
  localparam logic [7:0] UPPER_A = 8'h41;

  // Characters per line: "PPPP IIII\r\n"
  localparam int unsigned LINE_LEN = 11;

  typedef enum logic [1:0] {
    FMT_IDLE = 2'd0,
    FMT_LOAD = 2'd1,
    FMT_SEND = 2'd2,
    FMT_WAIT = 2'd3
  } fmt_state_e;

  // One captured trace entry
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } trace_entry_t;

  // Uppercase ASCII hex digit for a nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return ZERO + 8'(nibble);
    end
    return UPPER_A + 8'(nibble - 4'd10);
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// UART 8N1 transmitter: one start bit, eight data bits LSB first, one stop bit,
// each CLKS_PER_BIT clocks long.
// Ports: clk, reset (async active-low), start (one-cycle request, ignored while
// active), data (byte latched on start), tx (serial out, idle high),
// done (one cycle, during the last clock of the stop bit), active (frame in flight).
module uart_tx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       active
);

  localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       BIT_STOP = 4'd9;

  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  // Remaining data bits followed by the stop bit, shifted out LSB first
  logic [8:0]       shift_q, shift_d;

  // Bit timing and shifting
  always_comb begin
    tx_d     = tx_q;
    done_d   = 1'b0;
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        tx_d     = 1'b0;
        cnt_d    = '0;
        bit_d    = '0;
        shift_d  = {1'b1, data};
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (bit_q == BIT_STOP) begin
        active_d = 1'b0;
        tx_d     = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        tx_d    = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
      end
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      // Registered so it is high during the final clock of the stop bit
      done_d = (bit_q == BIT_STOP) && (cnt_q == CNT_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
    end else begin
      tx_q     <= tx_d;
      done_q   <= done_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  assign tx     = tx_q;
  assign done   = done_q;
  assign active = active_q;

endmodule

// File: rtl/trace_uart_tx.sv
// Instruction trace port: captures (pc, instr) pairs on valid into a FIFO and
// prints each as "PPPP IIII\r\n" in uppercase hex over a UART 8N1 pin.
// Ports: clk, reset (async active-low), valid/pc_in/instr_in (capture),
// tx (serial out), busy (FIFO or formatter active), overflow (sticky drop flag),
// fifo_count (entries held).
module trace_uart_tx
  import trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       instr_in,
  output logic              tx,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   fifo_count
);

  localparam int unsigned     CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]      IDX_LAST = 4'(LINE_LEN - 1);

  trace_entry_t      mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;

  fmt_state_e        state_q, state_d;
  trace_entry_t      line_q, line_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        char_q, char_d;
  logic              start_q, start_d;

  logic              push_c, pop_c;
  logic              uart_done, uart_active;

  // A new line is only started once the previous frame has left the wire
  assign pop_c  = (state_q == FMT_IDLE) && (count_q != '0) && !uart_active;
  assign push_c = valid && ((count_q != DEPTH) || pop_c);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= '{pc: pc_in, instr: instr_in};
    end
  end

  // FIFO bookkeeping, formatter FSM and status flags
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    line_d     = line_q;
    idx_d      = idx_q;
    char_d     = char_q;
    start_d    = 1'b0;

    if (push_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (valid && !push_c) overflow_d = 1'b1;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      FMT_IDLE: begin
        if (pop_c) begin
          line_d  = mem_q[rd_ptr_q];
          idx_d   = '0;
          state_d = FMT_LOAD;
        end
      end
      FMT_LOAD: begin
        case (idx_q)
          4'd0:    char_d = hex_ascii(line_q.pc[15:12]);
          4'd1:    char_d = hex_ascii(line_q.pc[11:8]);
          4'd2:    char_d = hex_ascii(line_q.pc[7:4]);
          4'd3:    char_d = hex_ascii(line_q.pc[3:0]);
          4'd4:    char_d = SPACE;
          4'd5:    char_d = hex_ascii(line_q.instr[15:12]);
          4'd6:    char_d = hex_ascii(line_q.instr[11:8]);
          4'd7:    char_d = hex_ascii(line_q.instr[7:4]);
          4'd8:    char_d = hex_ascii(line_q.instr[3:0]);
          4'd9:    char_d = CR;
          default: char_d = LF;
        endcase
        state_d = FMT_SEND;
      end
      FMT_SEND: begin
        start_d = 1'b1;
        state_d = FMT_WAIT;
      end
      FMT_WAIT: begin
        if (uart_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = FMT_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = FMT_LOAD;
          end
        end
      end
      default: state_d = FMT_IDLE;
    endcase

    // From next-state values so busy holds until the last stop bit completes
    busy_d = (count_d != '0) || (state_d != FMT_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      state_q    <= FMT_IDLE;
      line_q     <= '0;
      idx_q      <= '0;
      char_q     <= '0;
      start_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      state_q    <= state_d;
      line_q     <= line_d;
      idx_q      <= idx_d;
      char_q     <= char_d;
      start_q    <= start_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .reset  (reset),
    .start  (start_q),
    .data   (char_q),
    .tx     (tx),
    .done   (uart_done),
    .active (uart_active)
  );

  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Bench for trace_uart_tx with CLKS_PER_BIT=4: directed steps plus random bursts,
// a UART receiver decoding tx, and an expected byte stream built from the line format.
module tb_trace_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] pc_in = '0;
  logic [15:0] instr_in = '0;
  logic        tx, busy, overflow;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  int         rx_pos = 0;
  int         rx_frame_err = 0;
  logic [7:0] rx_byte = '0;

  always #5 clk = ~clk;

  trace_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(8),
    .ADDR_W(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  // Independent UART receiver, sampling 1.5 clocks into each bit
  always @(negedge clk) begin
    if (!reset) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == 1) begin
        rx_pos = rx_cnt / CPB;
        if (rx_pos == 0) begin
          if (tx !== 1'b0) rx_frame_err++;
        end else if (rx_pos <= 8) begin
          rx_byte[rx_pos-1] = tx;
        end else begin
          if (tx !== 1'b1) rx_frame_err++;
          rx_q.push_back(rx_byte);
          rx_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'(48 + int'(n));
    return 8'(65 + int'(n) - 10);
  endfunction

  task automatic make_line(input logic [15:0] pc, input logic [15:0] ins,
                           output logic [7:0] b[11]);
    for (int i = 0; i < 4; i++) b[i] = hexc(pc[4*(3-i) +: 4]);
    b[4] = 8'h20;
    for (int i = 0; i < 4; i++) b[5+i] = hexc(ins[4*(3-i) +: 4]);
    b[9]  = 8'h0D;
    b[10] = 8'h0A;
  endtask

  task automatic add_line(input logic [15:0] pc, input logic [15:0] ins);
    logic [7:0] b[11];
    make_line(pc, ins, b);
    for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
  endtask

  // Called at a negedge; the capture happens on the following posedge
  task automatic capture(input logic [15:0] pc, input logic [15:0] ins);
    valid    = 1'b1;
    pc_in    = pc;
    instr_in = ins;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic compare_rx(input string tag);
    int n;
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((busy !== 1'b0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_idle_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    logic [7:0] lb[11];
    logic       e;
    int         t, f, p, bi, peak, n, gap;
    logic [15:0] rpc, rins;

    // Reset state
    repeat (5) @(negedge clk);
    chk("reset_outputs", {tx, busy, overflow, fifo_count}, 32'h40);
    reset = 1'b1;

    // Idle after release with no captures
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("t1_idle", {tx, busy, overflow, fifo_count}, 32'h40);
    end

    // Single line, cycle-exact waveform; frame 5 carries 0x41
    make_line(16'h0004, 16'hA1F3, lb);
    add_line(16'h0004, 16'hA1F3);
    capture(16'h0004, 16'hA1F3);
    for (int k = 1; k <= 480; k++) begin
      @(negedge clk);
      if (k < 4) begin
        e = 1'b1;
        f = -1;
      end else begin
        t = k - 4;
        f = t / 43;
        p = t % 43;
        if (f > 10 || p >= 40) e = 1'b1;
        else begin
          bi = p / 4;
          if (bi == 0)      e = 1'b0;
          else if (bi == 9) e = 1'b1;
          else              e = lb[f][bi-1];
        end
      end
      chk((f == 5) ? "t3_bits_0x41" : "t2_tx", tx, e);
      chk("t2_busy", busy, 32'(k < 474));
    end
    compare_rx("t2_line");

    // Ten back-to-back captures: nine fit, the tenth overflows
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      capture(16'(i), 16'h1000 + 16'(i));
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    for (int i = 0; i < 9; i++) add_line(16'(i), 16'h1000 + 16'(i));
    chk("t4_peak_count", peak, 8);
    chk("t4_full_count", fifo_count, 8);
    chk("t4_overflow", overflow, 1);
    wait_idle(6000, "t4");
    compare_rx("t4_lines");

    // All-F and all-zero digits
    add_line(16'hFFFF, 16'h0000);
    capture(16'hFFFF, 16'h0000);
    wait_idle(1000, "t5");
    compare_rx("t5_line");

    // Random bursts that never exceed FIFO capacity
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        rpc  = 16'($urandom);
        rins = 16'($urandom);
        add_line(rpc, rins);
        capture(rpc, rins);
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
      end
      wait_idle(5000, "rand");
      compare_rx("rand_lines");
    end
    chk("overflow_sticky", overflow, 1);

    // Reset during data bit 3 of the first byte of the second line
    add_line(16'h0030, 16'h1234);
    capture(16'h0030, 16'h1234);
    capture(16'h0031, 16'h5678);
    capture(16'h0032, 16'h9ABC);
    repeat (492) @(negedge clk);
    chk("t6_pre_reset_tx", tx, 0);
    reset = 1'b0;
    #1;
    chk("t6_async_reset", {tx, busy, overflow, fifo_count}, 32'h40);
    compare_rx("t6_first_line");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("t6_quiet", {tx, busy, overflow, fifo_count}, 32'h40);
    end
    chk("t6_no_rx", rx_q.size(), 0);

    // Normal operation resumes after reset
    add_line(16'hBEEF, 16'hC0DE);
    capture(16'hBEEF, 16'hC0DE);
    wait_idle(1000, "t6_after");
    compare_rx("t6_after_line");
    chk("rx_framing", rx_frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
